jt08_adpcm_ram_arb: RTL and testbench
=====================================

# jt08_adpcm_ram_arb

Two-requester arbiter for the single external ADPCM sample RAM port. It shares that port between the ADPCM-B playback/record engine (requester A, real-time) and a secondary bus master such as the FDD/CPU DMA path (requester B). Sits between both requesters and the RAM. Replaces ad-hoc extra read waits with an explicit request/acknowledge handshake and a fixed memory latency.

## Interface
Parameters:
- AW, 21, address width in bytes
- MEM_LAT, 2, memory strobe duration in cen periods before read data is valid; legal range 1..15
- MAX_WAIT, 4, consecutive A grants tolerated while B is pending (anti-starvation only); legal range 1..15

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cen  in  1  8 MHz clock enable; all state advances only on clk & cen
- a_req  in  1  requester A access request, level, held until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A byte address
- a_wdata  in  8  A write data
- a_ack  out  1  A access complete
- a_rdata  out  8  A read data, valid from a_ack onward
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
- mem_addr  out  AW  RAM address
- mem_dout  out  8  RAM write data
- mem_din  in  8  RAM read data
- mem_rd  out  1  RAM read strobe, active-high
- mem_wr  out  1  RAM write strobe, active-high
- busy  out  1  high when state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, on cen: when a_req or b_req is high, the winner is chosen as follows.
  - Default: A wins.
  - B wins if only b_req is high, or if the starvation rule forces it.
  - On a grant, latch the winner's addr/we/wdata into mem_addr/mem_dout.
  - Assert mem_rd or mem_wr, record the grant owner, load cnt = MEM_LAT-1, go to ACCESS.
- ACCESS, on cen:
  - If cnt ≠ 0: decrement cnt.
  - If cnt = 0: deassert mem_rd/mem_wr. For a read, capture mem_din into the owner's rdata. Set the owner's ack. Go to DONE.
- DONE, on cen: clear ack and go to IDLE. Requests are not sampled in DONE.
- Non-owner rdata holds its value. mem_addr/mem_dout hold their last value in IDLE.
- Requester inputs are sampled only at grant. Changes to addr/wdata during ACCESS are ignored.
- A request dropped before its grant is simply not serviced. A request dropped after its grant still completes and is acknowledged.
- Starvation counter starve[3:0]:
  - Increments on each A grant made while b_req is high.
  - Clears on any B grant, and whenever b_req is low in IDLE.
  - When starve = MAX_WAIT, B wins the next IDLE arbitration even if a_req is high.

## Timing
- Reset values:
  - state = IDLE, starve = 0, owner = A.
  - mem_rd = mem_wr = 0.
  - a_ack = b_ack = 0, busy = 0.
  - mem_addr = 0, mem_dout = 0, a_rdata = b_rdata = 0.
- Reset asserted mid-access aborts immediately. Strobes and acks drop asynchronously. No ack is generated for the aborted access.
- Grant at cen edge G:
  - Strobe is high from G to G+MEM_LAT, i.e. exactly MEM_LAT cen periods.
  - mem_din is sampled at G+MEM_LAT.
  - ack is high from G+MEM_LAT to G+MEM_LAT+1, i.e. exactly one cen period.
- Earliest next grant is at G+MEM_LAT+2. The back-to-back access period is therefore MEM_LAT+2 cen periods.
- Requesters must sample ack on cen and drop req (or present a new request) by the next cen. The DONE state guarantees a held-over req is never re-granted.
- Simultaneous requests in IDLE resolve by the priority rule in one cen. There is no idle gap for the loser beyond the current access.

## Configuration
- JT08_ARB_STARVE_EN defined: the starvation counter is compiled in and enforces MAX_WAIT.
- JT08_ARB_STARVE_EN undefined: strict A priority. starve logic is removed, and B waits as long as a_req keeps winning.

## Test plan
- Single A read, MEM_LAT=2, mem_din=8'h5A, a_addr=21'h00123: mem_rd high for 2 cen with mem_addr=0x00123; a_ack one cen at G+2; a_rdata=8'h5A; b_ack stays 0.
- B write, b_addr=21'h1FFFF, b_wdata=8'hC3: mem_wr high for 2 cen with mem_dout=8'hC3; b_ack one cen; no mem_rd.
- a_req and b_req rise on the same cen: A granted first, then B granted at G+4; each ack fires exactly once.
- With JT08_ARB_STARVE_EN and MAX_WAIT=4, A re-requesting continuously and b_req held: B is granted after exactly 4 A grants. Without the macro, B is never granted while A persists.
- rst_n pulsed low during ACCESS of an A read: mem_rd and busy drop immediately with no a_ack. After release, a new request completes normally with latency MEM_LAT.
- req held high through DONE after ack: exactly one access is performed per request, and a second ack appears only if req is still high at the cen after DONE.

Source files
------------

// File: rtl/jt08_adpcm_ram_arb.sv
// jt08_adpcm_ram_arb
// Two-requester arbiter for the ADPCM sample RAM port. Requester A (ADPCM-B
// engine) has priority; requester B (DMA/CPU path) gets in when A is idle.
// Each access holds the RAM strobe for MEM_LAT cen periods. It then acks the
// owner for one cen period and spends one DONE period, so a held request is
// never re-granted on its own ack.
// Optional feature macro: JT08_ARB_STARVE_EN. When defined, B is forced
// through after MAX_WAIT consecutive A grants while it waits.
module jt08_adpcm_ram_arb #(
    parameter int AW       = 21,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;

    localparam logic [3:0] CNT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    state_t     state, state_nx;
    owner_t     owner;
    logic [3:0] cnt;
    logic       grant_a, grant_b;
    logic       b_force;

    assign busy = (state != IDLE);

`ifdef JT08_ARB_STARVE_EN
    logic [3:0] starve;

    assign b_force = (starve == MAX_WAIT_L);

    // Count A grants that B sat through; a B grant or an idle B clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= 4'd0;
        end else if (cen && state == IDLE) begin
            if (!b_req || grant_b) begin
                starve <= 4'd0;
            end else if (grant_a) begin
                starve <= starve + 4'd1;
            end
        end
    end
`else
    // MAX_WAIT only matters when the starvation counter is built in.
    logic unused_max_wait;

    assign b_force         = 1'b0;
    assign unused_max_wait = ^MAX_WAIT_L;
`endif

    // Arbitration: A wins by default, B wins alone or when forced through.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (b_req && (!a_req || b_force)) begin
                grant_b = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end
        end
    end

    // Next-state logic; DONE never looks at requests.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_a || grant_b) state_nx = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, advancing on clock-enabled edges only.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else if (cen) begin
            state <= state_nx;
        end
    end

    // Datapath: latch the winner at grant, time the strobe, return data/ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_A;
            cnt      <= 4'd0;
            mem_addr <= '0;
            mem_dout <= 8'd0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= 8'd0;
            b_rdata  <= 8'd0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    if (grant_b) begin
                        owner    <= OWN_B;
                        mem_addr <= b_addr;
                        mem_dout <= b_wdata;
                        mem_rd   <= !b_we;
                        mem_wr   <= b_we;
                        cnt      <= CNT_INIT;
                    end else if (grant_a) begin
                        owner    <= OWN_A;
                        mem_addr <= a_addr;
                        mem_dout <= a_wdata;
                        mem_rd   <= !a_we;
                        mem_wr   <= a_we;
                        cnt      <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (owner == OWN_B) begin
                            b_ack <= 1'b1;
                            if (mem_rd) b_rdata <= mem_din;
                        end else begin
                            a_ack <= 1'b1;
                            if (mem_rd) a_rdata <= mem_din;
                        end
                    end
                end
                DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt08_adpcm_ram_arb.sv
// tb_jt08_adpcm_ram_arb
// Scoreboard bench: stimulus pushes each expected access into exp_q; the
// monitor pops an entry on every grant it observes and checks strobe length,
// ack owner and width, read data and grant spacing. The RAM model returns
// mem_addr[7:0] ^ 8'h79 as read data.
// Respects JT08_ARB_STARVE_EN for the expected starvation ordering.
module tb_jt08_adpcm_ram_arb;

    localparam int AW      = 21;
    localparam int MEM_LAT = 2;

    typedef struct {
        bit          b;
        bit          we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          gap;
    } txn_t;

    logic          clk, rst_n, cen;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [7:0]    a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dout, mem_din;
    logic          mem_rd, mem_wr, busy;

    txn_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Monitor state
    txn_t       cur;
    bit         mon_active;
    bit         ack_seen;
    int         len;
    int         cen_idx;
    int         last_grant;
    logic [7:0] exp_ard, exp_brd;

    assign mem_din = mem_addr[7:0] ^ 8'h79;

    jt08_adpcm_ram_arb #(.AW(AW), .MEM_LAT(MEM_LAT), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cen is high on every other rising edge
    initial begin
        cen = 1'b0;
        forever begin
            @(negedge clk);
            cen = ~cen;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        do @(posedge clk); while (!cen);
        #1;
    endtask

    task automatic expect_txn(input bit b, input bit we, input logic [20:0] addr,
                              input logic [7:0] wd, input logic [7:0] rd, input int gap);
        txn_t t;
        t.b = b; t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rd; t.gap = gap;
        exp_q.push_back(t);
    endtask

    task automatic wait_ack(input bit b, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(b ? b_ack : a_ack) && n < 40);
        if (!(b ? b_ack : a_ack)) check(name, 32'(b ? b_ack : a_ack), 32'd1);
    endtask

    task automatic access(input bit b, input bit we, input logic [20:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd, input string name);
        expect_txn(b, we, addr, wd, rd, 0);
        if (b) begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end
        wait_ack(b, name);
        if (b) b_req = 1'b0;
        else   a_req = 1'b0;
        repeat (2) tick();
    endtask

    // Monitor: one sample per cen edge, compared against the scoreboard
    initial begin
        mon_active = 0; ack_seen = 0; len = 0; cen_idx = 0; last_grant = -1;
        exp_ard = 8'd0; exp_brd = 8'd0;
        forever begin
            @(posedge clk);
            if (!cen) continue;
            #2;
            cen_idx++;
            if (!rst_n) begin
                mon_active = 0; ack_seen = 0; last_grant = -1;
                exp_ard = 8'd0; exp_brd = 8'd0;
                continue;
            end
            if (ack_seen) begin
                check("ack_width", {30'd0, a_ack, b_ack}, 32'd0);
                check("done_busy", 32'(busy), 32'd0);
                ack_seen = 0;
            end
            if (!mon_active) begin
                if (mem_rd || mem_wr) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", {30'd0, mem_rd, mem_wr}, 32'd0);
                    end else begin
                        cur = exp_q.pop_front();
                        mon_active = 1;
                        len = 1;
                        check("grant_owner_addr", 32'(mem_addr), 32'(cur.addr));
                        check("grant_strobe", {30'd0, mem_rd, mem_wr}, cur.we ? 32'd1 : 32'd2);
                        if (cur.we) check("grant_wdata", 32'(mem_dout), 32'(cur.wdata));
                        check("grant_busy", 32'(busy), 32'd1);
                        if (cur.gap != 0) check("grant_gap", 32'(cen_idx - last_grant), 32'(cur.gap));
                        last_grant = cen_idx;
                    end
                end else if (a_ack || b_ack) begin
                    check("spurious_ack", {30'd0, a_ack, b_ack}, 32'd0);
                end
            end else if (mem_rd || mem_wr) begin
                len++;
                if (a_ack || b_ack) check("early_ack", {30'd0, a_ack, b_ack}, 32'd0);
            end else begin
                check("strobe_len", 32'(len), 32'(MEM_LAT));
                check("ack_owner", {30'd0, a_ack, b_ack}, cur.b ? 32'd1 : 32'd2);
                if (!cur.we) begin
                    if (cur.b) exp_brd = cur.rdata;
                    else       exp_ard = cur.rdata;
                end
                check("a_rdata", 32'(a_rdata), 32'(exp_ard));
                check("b_rdata", 32'(b_rdata), 32'(exp_brd));
                mon_active = 0;
                ack_seen = 1;
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = 8'd0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = 8'd0;
        #27;
        check("rst_mem_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single accesses: A read, B write, A write
        access(0, 0, 21'h00123, 8'h00, 8'h5A, "a_read_ack_timeout");
        access(1, 1, 21'h1FFFF, 8'hC3, 8'h00, "b_write_ack_timeout");
        access(0, 1, 21'h00077, 8'h3E, 8'h00, "a_write_ack_timeout");

        // Simultaneous requests: A first, B granted MEM_LAT+2 later
        expect_txn(0, 0, 21'h00245, 8'h00, 8'h3C, 0);
        expect_txn(1, 0, 21'h00391, 8'h00, 8'hE8, MEM_LAT + 2);
        a_we = 0; a_addr = 21'h00245;
        b_we = 0; b_addr = 21'h00391;
        a_req = 1; b_req = 1;
        wait_ack(0, "sim_a_ack_timeout");
        a_req = 0;
        wait_ack(1, "sim_b_ack_timeout");
        b_req = 0;
        repeat (2) tick();

        // Request held through DONE, dropped before IDLE: exactly one access
        expect_txn(0, 0, 21'h0F0F0, 8'h00, 8'h89, 0);
        a_we = 0; a_addr = 21'h0F0F0; a_req = 1;
        wait_ack(0, "held_ack_timeout");
        tick();
        a_req = 0;
        repeat (4) tick();
        check("held_single_access", 32'(exp_q.size()), 32'd0);

        // A held continuously with B pending
        a_we = 0; a_addr = 21'h00010;
        b_we = 1; b_addr = 21'h00055; b_wdata = 8'h5C;
`ifdef JT08_ARB_STARVE_EN
        for (int k = 0; k < 4; k++) expect_txn(0, 0, 21'h00010, 8'h00, 8'h69, (k == 0) ? 0 : MEM_LAT + 2);
        expect_txn(1, 1, 21'h00055, 8'h5C, 8'h00, MEM_LAT + 2);
        expect_txn(0, 0, 21'h00010, 8'h00, 8'h69, MEM_LAT + 2);
        a_req = 1; b_req = 1;
        for (int k = 0; k < 4; k++) wait_ack(0, "starve_a_ack_timeout");
        wait_ack(1, "starve_b_ack_timeout");
        b_req = 0;
        wait_ack(0, "starve_a_last_timeout");
        a_req = 0;
`else
        for (int k = 0; k < 6; k++) expect_txn(0, 0, 21'h00010, 8'h00, 8'h69, (k == 0) ? 0 : MEM_LAT + 2);
        expect_txn(1, 1, 21'h00055, 8'h5C, 8'h00, MEM_LAT + 2);
        a_req = 1; b_req = 1;
        for (int k = 0; k < 6; k++) wait_ack(0, "prio_a_ack_timeout");
        a_req = 0;
        wait_ack(1, "prio_b_ack_timeout");
        b_req = 0;
`endif
        repeat (2) tick();

        // Reset in the middle of an A read
        expect_txn(0, 0, 21'h00ABC, 8'h00, 8'hC5, 0);
        a_we = 0; a_addr = 21'h00ABC; a_req = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_rd && n < 20);
        check("abort_grant_seen", 32'(mem_rd), 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_a_ack", 32'(a_ack), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        a_req = 0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        check("abort_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
        access(0, 0, 21'h00100, 8'h00, 8'h79, "post_reset_ack_timeout");

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("monitor_idle", 32'(mon_active), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
